demux_dispatch_ctrl: RTL and testbench
======================================

// Module: demux_dispatch_ctrl
// PURPOSE
//  Sequencing controller for the 1-to-4 demux datapath. Takes one source stream (valid/ready),
//  registers each item and routes it to one of 4 sinks, by round-robin or by explicit destination.
//  Drives the demux select (s1,s0) and valid input; retargets a stalled round-robin item after a timeout.
//  Sits between a single producer and four consumer channels.
// PARAMETERS
//  DW       8    data width of in_data/out_data
//  TIMEOUT  16   cycles a RR item may wait unaccepted before retarget; 0 = retarget disabled
//  TW       5    wait-counter width; must hold TIMEOUT
// PORTS
//  clk          in   1    single clock, rising edge
//  rst          in   1    asynchronous, active-high reset
//  enable       in   1    1 = accept new items; 0 = drain only
//  in_valid     in   1    source item valid
//  in_ready     out  1    controller can take item this cycle
//  in_data      in   DW   source payload
//  in_mode      in   1    0 = round-robin, 1 = directed (use in_dest)
//  in_dest      in   2    destination channel when in_mode=1
//  out_valid    out  4    one-hot channel valid (demux of hold flag by sel)
//  out_ready    in   4    per-channel sink ready
//  out_data     out  DW   registered payload, shared by all channels
//  sel          out  2    current channel select {s1,s0}
//  timeout_evt  out  1    1-cycle pulse when a held RR item is retargeted
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, out_data=0, sel=0, rr_ptr=0, wait_cnt=0, timeout_evt=0;
//   reset mid-operation discards any held item.
//  States: IDLE (no item held), HOLD (item held, out_valid[sel]=1).
//  accept = HOLD && out_ready[sel]; load = in_valid && in_ready.
//  in_ready = enable && (IDLE || accept), combinational; full throughput, 1 item/cycle.
//  Latency: load at edge N -> out_valid[sel]=1 from cycle N+1; out_data stable while HOLD.
//  On load: out_data<=in_data; held_mode<=in_mode; sel<=in_mode ? in_dest : rr_ptr;
//   if in_mode=0, rr_ptr<=rr_ptr+1 (mod 4, 3->0); directed loads leave rr_ptr unchanged.
//  Transitions: IDLE->HOLD on load; HOLD->IDLE on accept && !load; HOLD->HOLD on accept && load
//   (back-to-back, new item replaces old, wait_cnt<=0).
//  Wait counter: in HOLD without accept, wait_cnt increments; cleared on load/accept.
//  Retarget: HOLD && held_mode=0 && TIMEOUT!=0 && !accept && wait_cnt==TIMEOUT-1 ->
//   sel<=sel+1 mod 4, wait_cnt<=0, timeout_evt=1 next cycle; rr_ptr unaffected.
//  Accept wins over retarget in the same cycle. Directed items never retarget; they wait forever.
//  enable=0: in_ready=0; held item still drains and may retarget.
//  out_valid is never multi-hot; out_ready on non-selected channels is ignored.
// STRUCTURE
//  Package demux_pkg: NCH=4, SEL_W=2, state enum {IDLE, HOLD}, MODE_RR/MODE_DIR constants.
//  Sub-module: instantiate existing combinational demux for out_valid
//   (i=state==HOLD, s1=sel[1], s0=sel[0], y3..y0 -> out_valid[3:0]).
//  All state in one always_ff with async rst; in_ready/accept combinational.
// TESTING
//  1 RR stream: 6 items 0xA0..0xA5, all out_ready=1 -> delivered ch0,1,2,3,0,1, one/cycle, rr wraps 3->0.
//  2 Directed: in_mode=1, dest=2, data 0x5A, out_ready=4'b0100 after 3 cycles -> only out_valid[2], held 3 cycles, rr_ptr stays 0.
//  3 Timeout: TIMEOUT=4, RR item to ch1, out_ready=0 -> sel 1->2 after 4 cycles, timeout_evt pulse; ch2 ready -> accept.
//  4 Accept/retarget tie: out_ready[sel] rises on wait_cnt==TIMEOUT-1 -> item accepted on old sel, no timeout_evt.
//  5 Back-pressure+enable: enable=0 while HOLD -> in_ready=0, held item drains, state IDLE, no new load.
//  6 Reset mid-HOLD: assert rst asynchronously -> out_valid=0, sel=0 immediately; post-reset first RR item goes to ch0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 demux dispatch controller.
package demux_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_DIR = 1'b1;

  // Channel successor; the 2-bit add wraps 3 -> 0 on its own.
  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
    return ch + SEL_W'(1);
  endfunction

endpackage

// File: rtl/demux_dispatch_ctrl_demux.sv
// Combinational 1-to-4 demux: routes input i to the output selected by {s1,s0}.
module demux_dispatch_ctrl_demux (
  input  logic i_i,
  input  logic s1_i,
  input  logic s0_i,
  output logic y3_o,
  output logic y2_o,
  output logic y1_o,
  output logic y0_o
);

  assign y0_o = i_i & ~s1_i & ~s0_i;
  assign y1_o = i_i & ~s1_i &  s0_i;
  assign y2_o = i_i &  s1_i & ~s0_i;
  assign y3_o = i_i &  s1_i &  s0_i;

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Dispatch controller: registers one source item at a time and routes it to one of
// four sinks, round-robin or directed, retargeting stalled round-robin items.
module demux_dispatch_ctrl
  import demux_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_mode,
  input  logic [SEL_W-1:0] in_dest,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [DW-1:0]    out_data,
  output logic [SEL_W-1:0] sel,
  output logic             timeout_evt
);

  localparam bit            RETARGET_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0] WAIT_LAST   = RETARGET_EN ? TW'(TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  logic [DW-1:0]    data_q, data_d;
  logic             mode_q, mode_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_q, rr_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic             evt_q, evt_d;

  logic hold;
  logic accept;
  logic load;
  logic retarget;

  assign hold     = (state_q == HOLD);
  assign accept   = hold && out_ready[sel_q];
  assign in_ready = enable && (!hold || accept);
  assign load     = in_valid && in_ready;
  // A sink that becomes ready on the last wait cycle still takes the item on the old channel.
  assign retarget = hold && (mode_q == MODE_RR) && RETARGET_EN && !accept && (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    wait_d  = wait_q;
    evt_d   = retarget;
    if (load) begin
      state_d = HOLD;
      data_d  = in_data;
      mode_d  = in_mode;
      wait_d  = '0;
      if (in_mode == MODE_DIR) begin
        sel_d = in_dest;
      end else begin
        sel_d = rr_q;
        rr_d  = next_ch(rr_q);
      end
    end else if (accept) begin
      state_d = IDLE;
      wait_d  = '0;
    end else if (retarget) begin
      sel_d  = next_ch(sel_q);
      wait_d = '0;
    end else if (hold) begin
      wait_d = wait_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      mode_q  <= MODE_RR;
      sel_q   <= '0;
      rr_q    <= '0;
      wait_q  <= '0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      wait_q  <= wait_d;
      evt_q   <= evt_d;
    end
  end

  demux_dispatch_ctrl_demux u_demux (
    .i_i  (hold),
    .s1_i (sel_q[1]),
    .s0_i (sel_q[0]),
    .y3_o (out_valid[3]),
    .y2_o (out_valid[2]),
    .y1_o (out_valid[1]),
    .y0_o (out_valid[0])
  );

  assign out_data    = data_q;
  assign sel         = sel_q;
  assign timeout_evt = evt_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: directed scenarios plus a random phase,
// all checked every cycle against a behavioural model of the dispatch rules.
module tb_demux_dispatch_ctrl;

  localparam int DW  = 8;
  localparam int TMO = 4;
  localparam int TW  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_mode;
  logic [1:0]    in_dest;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    sel;
  logic          timeout_evt;

  always #5 clk = ~clk;

  demux_dispatch_ctrl #(.DW(DW), .TIMEOUT(TMO), .TW(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_mode     (in_mode),
    .in_dest     (in_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .sel         (sel),
    .timeout_evt (timeout_evt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: "is an item held, which channel, what payload, how long waiting".
  bit            m_held;
  logic [DW-1:0] m_data;
  bit            m_dir;
  int            m_sel, m_rr, m_wait;
  bit            m_evt;

  wire m_acc      = m_held && out_ready[m_sel];
  wire m_in_ready = enable && (!m_held || m_acc);
  wire m_load     = in_valid && m_in_ready;
  wire m_rt       = m_held && !m_dir && (TMO != 0) && !m_acc && (m_wait == TMO - 1);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_held <= 0; m_data <= '0; m_dir <= 0;
      m_sel <= 0; m_rr <= 0; m_wait <= 0; m_evt <= 0;
    end else begin
      m_evt <= m_rt;
      if (m_load) begin
        m_held <= 1;
        m_data <= in_data;
        m_dir  <= in_mode;
        m_wait <= 0;
        if (in_mode) m_sel <= int'(in_dest);
        else begin
          m_sel <= m_rr;
          m_rr  <= (m_rr + 1) % 4;
        end
      end else if (m_acc) begin
        m_held <= 0;
        m_wait <= 0;
      end else if (m_rt) begin
        m_sel  <= (m_sel + 1) % 4;
        m_wait <= 0;
      end else if (m_held) begin
        m_wait <= m_wait + 1;
      end
    end
  end

  typedef struct { int ch; int data; } dlv_t;
  dlv_t dut_log[$];
  int   evt_seen;

  // Per-cycle compare against the model, plus a record of what the DUT actually delivered.
  always @(negedge clk) begin
    chk("out_valid", {28'd0, out_valid}, m_held ? (32'd1 << m_sel) : 32'd0);
    chk("sel", {30'd0, sel}, 32'(m_sel));
    chk("out_data", {24'd0, out_data}, {24'd0, m_data});
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
    chk("timeout_evt", {31'd0, timeout_evt}, {31'd0, m_evt});
    if (timeout_evt) evt_seen++;
    if ((out_valid & out_ready) != 4'd0) begin
      dut_log.push_back('{int'(sel), int'(out_data)});
      $display("deliver ch=%0d data=%02h t=%0t", sel, out_data, $time);
    end
  end

  task automatic adv(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1; in_valid = 0; in_data = '0; in_mode = 0; in_dest = 0; out_ready = 4'h0;
  endtask

  task automatic do_reset();
    adv();
    rst = 1;
    idle_inputs();
    adv();
    rst = 0;
    dut_log.delete();
    evt_seen = 0;
  endtask

  task automatic chk_log(input string nm, input int idx, input int ch, input int data);
    if (idx < dut_log.size()) begin
      chk({nm, "_ch"}, 32'(dut_log[idx].ch), 32'(ch));
      chk({nm, "_data"}, 32'(dut_log[idx].data), 32'(data));
    end else begin
      chk({nm, "_present"}, 32'(dut_log.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    evt_seen = 0;
    #12;
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_evt", {31'd0, timeout_evt}, 32'd0);
    adv();
    rst = 0;

    // 1: round-robin stream, always-ready sinks, one delivery per cycle, pointer wraps
    do_reset();
    in_valid = 1; out_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'hA0 + 8'(i);
      adv();
    end
    in_valid = 0;
    adv(2);
    chk("s1_count", 32'(dut_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk_log("s1", i, i % 4, 'hA0 + i);

    // 2: directed item to ch2, held 3 cycles, round-robin pointer untouched
    do_reset();
    in_valid = 1; in_mode = 1; in_dest = 2; in_data = 8'h5A;
    adv();
    in_valid = 0; in_mode = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) out_ready = 4'b0100;
      #1 chk("s2_hold_valid", {28'd0, out_valid}, 32'b0100);
      adv();
    end
    #1 chk("s2_after_valid", {28'd0, out_valid}, 32'd0);
    in_valid = 1; in_data = 8'h11; out_ready = 4'hF;
    adv();
    in_valid = 0;
    adv(2);
    chk_log("s2_dir", 0, 2, 'h5A);
    chk_log("s2_rr", 1, 0, 'h11);

    // 3: RR item on ch1 stalls, retargets to ch2 after 4 cycles, then accepted there
    do_reset();
    in_valid = 1; in_data = 8'h31;
    adv();
    in_data = 8'h32; out_ready = 4'hF;
    adv();
    in_valid = 0; out_ready = 4'h0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("s3_wait_sel", {30'd0, sel}, 32'd1);
      chk("s3_wait_evt", {31'd0, timeout_evt}, 32'd0);
      adv();
    end
    #1 chk("s3_rt_sel", {30'd0, sel}, 32'd2);
    chk("s3_rt_evt", {31'd0, timeout_evt}, 32'd1);
    out_ready = 4'b0100;
    adv();
    #1 chk("s3_done_evt", {31'd0, timeout_evt}, 32'd0);
    adv();
    chk_log("s3", 1, 2, 'h32);

    // 4: sink becomes ready on the last wait cycle -> accepted on the original channel
    do_reset();
    in_valid = 1; in_data = 8'h41;
    adv();
    in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) out_ready = 4'b0001;
      adv();
    end
    out_ready = 4'h0;
    adv(3);
    chk("s4_evt_seen", 32'(evt_seen), 32'd0);
    chk("s4_count", 32'(dut_log.size()), 32'd1);
    chk_log("s4", 0, 0, 'h41);

    // 5: enable dropped while holding: held item drains, nothing new is taken
    do_reset();
    in_valid = 1; in_data = 8'h51;
    adv();
    enable = 0; in_data = 8'h52;
    #1 chk("s5_ready_hold", {31'd0, in_ready}, 32'd0);
    adv();
    out_ready = 4'hF;
    #1 chk("s5_ready_acc", {31'd0, in_ready}, 32'd0);
    adv();
    #1 chk("s5_idle_valid", {28'd0, out_valid}, 32'd0);
    adv(2);
    chk("s5_count", 32'(dut_log.size()), 32'd1);
    chk_log("s5", 0, 0, 'h51);
    in_valid = 0; enable = 1;

    // 6: asynchronous reset mid-hold clears outputs immediately; next RR item -> ch0
    do_reset();
    in_valid = 1; in_mode = 1; in_dest = 3; in_data = 8'h61;
    adv();
    in_valid = 0; in_mode = 0;
    #1 chk("s6_pre_sel", {30'd0, sel}, 32'd3);
    #1 rst = 1;
    #1 chk("s6_rst_valid", {28'd0, out_valid}, 32'd0);
    chk("s6_rst_sel", {30'd0, sel}, 32'd0);
    adv();
    rst = 0;
    dut_log.delete();
    in_valid = 1; in_data = 8'h62; out_ready = 4'hF;
    adv();
    in_valid = 0;
    adv(2);
    chk_log("s6", 0, 0, 'h62);

    // Random phase: mixed modes, sparse sink readiness so retargets occur
    do_reset();
    for (int c = 0; c < 300; c++) begin
      enable    = ($urandom_range(0, 7) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      in_mode   = ($urandom_range(0, 3) == 0);
      in_dest   = 2'($urandom);
      out_ready = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      adv();
    end
    idle_inputs();
    adv(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
